// File: rtl/bus_grant_arbiter_if.sv
// Bus arbitration handshake bundle: per-source requests and owner release in,
// one-hot grant, encoded owner index and forced-release flag out.
interface bus_grant_arbiter_if;
    logic [31:0] req;
    logic        rel;
    logic [31:0] gnt;
    logic        gnt_valid;
    logic [4:0]  gnt_idx;
    logic        to_err;

    modport master (
        output req,
        output rel,
        input  gnt,
        input  gnt_valid,
        input  gnt_idx,
        input  to_err
    );

    modport slave (
        input  req,
        input  rel,
        output gnt,
        output gnt_valid,
        output gnt_idx,
        output to_err
    );
endinterface

// File: rtl/bus_grant_arbiter.sv
// Round-robin owner arbiter for the 32-source internal bus, with one dead cycle between owners.
// Define BUS_GRANT_TIMEOUT_EN to build the hold counter that forces release after TIMEOUT cycles.
module bus_grant_arbiter #(
    parameter int NREQ    = 32,
    parameter int IDXW    = 5
`ifdef BUS_GRANT_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic                 clk,
    input  logic                 clr,
    bus_grant_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              to_err_q, to_err_d;

    logic [IDXW-1:0]   win_idx;
    logic              win_found;
    logic              rel_now;
    logic              timeout_hit;

    // Scan from farthest to nearest so the first requester after ptr overrides the rest.
    always_comb begin
        logic [IDXW-1:0] cand;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = ptr_q + k[IDXW-1:0];
            if (bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign rel_now = bus.rel || !bus.req[idx_q];

`ifdef BUS_GRANT_TIMEOUT_EN
    localparam int CNTW = 5;
    logic [CNTW-1:0] cnt_q;

    // Counter sits at zero outside BUSY, so it is already cleared on entry.
    always_ff @(posedge clk) begin
        if (clr || state_q != BUSY) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == BUSY) && (cnt_q == CNTW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            ptr_q    <= '1;
            idx_q    <= '1;
            valid_q  <= 1'b0;
            gnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            gnt_q    <= gnt_d;
            to_err_q <= to_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, TURN: state_d = win_found ? BUSY : IDLE;
            BUSY:       if (rel_now || timeout_hit) state_d = TURN;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        to_err_d = 1'b0;
        if (state_q == BUSY) begin
            if (rel_now || timeout_hit) begin
                valid_d  = 1'b0;
                idx_d    = '1;
                to_err_d = timeout_hit && !rel_now;
            end
        end else if (win_found) begin
            valid_d = 1'b1;
            idx_d   = win_idx;
            ptr_d   = win_idx;
        end else begin
            valid_d = 1'b0;
            idx_d   = '1;
        end
    end

    // One-hot decode of the next owner; registered alongside idx/valid.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
        assign gnt_d[gi] = valid_d && (idx_d == IDXW'(gi));
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = valid_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.to_err    = to_err_q;

endmodule
